data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter ADDR_W, default 13: byte-address width; capacity 2**ADDR_W bytes.
REQ-002 Parameter LATENCY, default 4: access latency in clock cycles; legal range 1..15.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_rd  input  1  read request; sampled only in IDLE.
REQ-006 req_wr  input  1  write request; sampled only in IDLE.
REQ-007 req_addr  input  32  byte address; bits [1:0] ignored (word-aligned access).
REQ-008 mem_data_in  input  4x8 (lanes 0..3)  write data; lane i goes to byte base+i.
REQ-009 mem_data_out  output  4x8 (lanes 0..3)  read data; lane i is the byte at base+i.
REQ-010 busy  output  1  high while a request is in flight.
REQ-011 data_ready  output  1  one-cycle pulse; read data valid on mem_data_out.
REQ-012 wr_done  output  1  one-cycle pulse; write committed.
REQ-013 err  output  1  one-cycle pulse with data_ready/wr_done; address out of range.

Function
REQ-014 The block SHALL store 2**ADDR_W bytes, organised as 2**(ADDR_W-2) words of four byte lanes.
REQ-015 The FSM SHALL have states IDLE, RD_WAIT and WR_WAIT.
REQ-016 In IDLE, a rising edge with req_wr=1 SHALL latch req_addr and all four lanes of mem_data_in, load the counter, and enter WR_WAIT.
REQ-017 In IDLE, a rising edge with req_rd=1 and req_wr=0 SHALL latch req_addr, load the counter, and enter RD_WAIT.
REQ-018 Simultaneous req_rd and req_wr SHALL be served as a write only; the read is dropped and the initiator must re-request it.
REQ-019 busy SHALL be 1 from the accepting edge k up to, but not including, edge k+LATENCY; it SHALL be 0 in the cycle after edge k+LATENCY.
REQ-020 Requests presented while busy=1 SHALL be ignored; a new request is accepted no earlier than edge k+LATENCY+1.
REQ-021 Completion SHALL occur at edge k+LATENCY, after which the FSM SHALL return to IDLE.
REQ-022 Read completion SHALL drive mem_data_out with the four bytes at the latched base address and pulse data_ready for exactly one cycle.
REQ-023 mem_data_out SHALL hold its last read value until the next read completes; writes SHALL NOT change it.
REQ-024 Write completion SHALL commit all four latched lanes and pulse wr_done for exactly one cycle.
REQ-025 Changes to mem_data_in after acceptance SHALL have no effect on the committed data.
REQ-026 If latched addr[31:ADDR_W] is nonzero, completion SHALL pulse err together with the done pulse.
REQ-027 An out-of-range read SHALL return mem_data_out = 0; an out-of-range write SHALL leave the array unchanged.
REQ-028 A read issued after a completed write to the same word SHALL return the written bytes.
REQ-029 Array contents SHALL be all-zero at simulation start.
REQ-030 The counter SHALL be wide enough for LATENCY; it SHALL neither wrap nor go negative.

Reset
REQ-031 rst=0 SHALL asynchronously force state IDLE and counter 0.
REQ-032 rst=0 SHALL asynchronously force busy=0, data_ready=0, wr_done=0, err=0 and all mem_data_out lanes = 8'h00.
REQ-033 Reset SHALL NOT modify array contents.
REQ-034 Reset asserted during WR_WAIT SHALL abort the write with no commit; reset during RD_WAIT SHALL abort with no data_ready pulse.
REQ-035 After rst deasserts, the first request SHALL be accepted on the next rising edge.

Verification
REQ-036 Write then read: write addr 0x0000_0010, lanes {0x11,0x22,0x33,0x44}, then read 0x10 -> wr_done at edge k+4; mem_data_out = {0x11,0x22,0x33,0x44} with data_ready at edge k'+4; busy low 1 cycle between.
REQ-037 Simultaneous request and busy drop: req_rd=req_wr=1 at 0x20 -> write only, no data_ready. req_rd pulsed mid-busy -> ignored, with exactly one done pulse per accepted request.
REQ-038 Out-of-range access: read 0x0000_2000 (ADDR_W=13) -> err and data_ready together, mem_data_out=0. Write to 0x2000 -> err with wr_done; a later read of 0x0000 is unchanged.
REQ-039 Reset abort: write 0xAABBCCDD to 0x40, rst=0 two cycles after accept -> no wr_done, all outputs 0 immediately; read 0x40 after reset returns the prior contents (0).
REQ-040 Latency and alignment: LATENCY=1 with back-to-back reads of 0x10 and 0x13 -> each done exactly one edge after acceptance; both return the same word (addr[1:0] ignored).

Source files
------------

// File: rtl/data_memory_if.sv
// data_memory bus: request/addr/write-lanes in; read-lanes, busy and
// done/err pulses out. Lane i of a word is the byte at base+i.
interface data_memory_if;
  logic            req_rd;
  logic            req_wr;
  logic [31:0]     req_addr;
  logic [3:0][7:0] mem_data_in;
  logic [3:0][7:0] mem_data_out;
  logic            busy;
  logic            data_ready;
  logic            wr_done;
  logic            err;

  modport master (
    output req_rd, req_wr, req_addr, mem_data_in,
    input  mem_data_out, busy, data_ready, wr_done, err
  );

  modport slave (
    input  req_rd, req_wr, req_addr, mem_data_in,
    output mem_data_out, busy, data_ready, wr_done, err
  );
endinterface

// File: rtl/data_memory.sv
// Fixed-latency word-organised byte memory, 2**ADDR_W bytes.
// Ports: clk, rst (async active-low), bus (data_memory_if.slave).
module data_memory #(
  parameter int ADDR_W  = 13,
  parameter int LATENCY = 4
) (
  input logic          clk,
  input logic          rst,
  data_memory_if.slave bus
);

  localparam int WORDS = 2 ** (ADDR_W - 2);
  localparam int CW    = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0][7:0] wdata_q, wdata_d;
  logic [3:0][7:0] dout_q, dout_d;
  logic            rdy_q, rdy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic              fin;
  logic              oor;
  logic              mem_we;
  logic [ADDR_W-3:0] widx;
  logic [1:0]        unused_lsb;

  logic [3:0][7:0] mem_q [WORDS] = '{default: '0};

  // Counter holds the edges remaining before completion.
  assign fin        = (state_q != IDLE) && (cnt_q == '0);
  assign oor        = |addr_q[31:ADDR_W];
  assign widx       = addr_q[ADDR_W-1:2];
  assign unused_lsb = addr_q[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        // A write wins over a simultaneous read.
        if (bus.req_wr) begin
          state_d = WR_WAIT;
          cnt_d   = CNT_LOAD;
          addr_d  = bus.req_addr;
          wdata_d = bus.mem_data_in;
        end else if (bus.req_rd) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_LOAD;
          addr_d  = bus.req_addr;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy_d  = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    dout_d = dout_q;
    mem_we = 1'b0;
    if (fin) begin
      err_d = oor;
      if (state_q == RD_WAIT) begin
        rdy_d  = 1'b1;
        dout_d = oor ? '0 : mem_q[widx];
      end else begin
        done_d = 1'b1;
        mem_we = !oor;
      end
    end
  end

  // No reset: contents survive rst; an aborted write never
  // reaches fin because state is forced to IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[widx] <= wdata_q;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.data_ready   = rdy_q;
  assign bus.wr_done      = done_q;
  assign bus.err          = err_q;
  assign bus.mem_data_out = dout_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: LATENCY=4 and LATENCY=1
// instances, expectations queued at accept, checked at done.
module tb_data_memory;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_if ifa ();
  data_memory_if ifb ();

  data_memory #(.ADDR_W(13), .LATENCY(4)) u_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  data_memory #(.ADDR_W(13), .LATENCY(1)) u_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] ad   [2];
  logic [31:0] din  [2];
  logic        busy [2];
  logic        drdy [2];
  logic        wdn  [2];
  logic        er   [2];
  logic [31:0] dout [2];

  assign ifa.req_rd      = rd[0];
  assign ifa.req_wr      = wr[0];
  assign ifa.req_addr    = ad[0];
  assign ifa.mem_data_in = din[0];
  assign ifb.req_rd      = rd[1];
  assign ifb.req_wr      = wr[1];
  assign ifb.req_addr    = ad[1];
  assign ifb.mem_data_in = din[1];

  assign busy[0] = ifa.busy;
  assign drdy[0] = ifa.data_ready;
  assign wdn[0]  = ifa.wr_done;
  assign er[0]   = ifa.err;
  assign dout[0] = ifa.mem_data_out;
  assign busy[1] = ifb.busy;
  assign drdy[1] = ifb.data_ready;
  assign wdn[1]  = ifb.wr_done;
  assign er[1]   = ifb.err;
  assign dout[1] = ifb.mem_data_out;

  typedef struct {
    int          dut;
    bit          is_wr;
    bit          err;
    logic [10:0] word;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q [$];
  logic [31:0] mdl  [2][2048];
  logic [31:0] last [2];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp,
               $time);
    end
  endtask

  function automatic int lat(input int s);
    return (s == 1) ? 1 : 4;
  endfunction

  // Called at a negedge; request is accepted at the next posedge.
  task automatic issue(input int s, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    rd[s]  = r;
    wr[s]  = w;
    ad[s]  = a;
    din[s] = d;
    @(posedge clk);
    #1;
    rd[s]   = 1'b0;
    wr[s]   = 1'b0;
    din[s]  = ~d;
    e.dut   = s;
    e.is_wr = w;
    e.err   = |a[31:13];
    e.word  = a[12:2];
    if (w)          e.data = d;
    else if (e.err) e.data = '0;
    else            e.data = mdl[s][a[12:2]];
    e.cyc = cyc + lat(s);
    q.push_back(e);
    @(negedge clk);
    chk("busy_after_accept", {31'd0, busy[s]}, 32'd1);
  endtask

  task automatic wait_done(input int s);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (drdy[s] || wdn[s]) return;
    end
    chk("done_timeout", {31'd0, drdy[s] | wdn[s]}, 32'd1);
    q.delete();
  endtask

  task automatic mon(input int s);
    exp_t e;
    if (drdy[s] || wdn[s]) begin
      if (q.size() == 0 || q[0].dut != s) begin
        chk("spurious_done", {30'd0, drdy[s], wdn[s]}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("wr_done", {31'd0, wdn[s]}, {31'd0, e.is_wr});
        chk("data_ready", {31'd0, drdy[s]}, {31'd0, !e.is_wr});
        chk("done_cycle", cyc, e.cyc);
        chk("err", {31'd0, er[s]}, {31'd0, e.err});
        chk("busy_at_done", {31'd0, busy[s]}, 32'd0);
        if (e.is_wr) begin
          chk("dout_hold", dout[s], last[s]);
          if (!e.err) mdl[s][e.word] = e.data;
        end else begin
          chk("rdata", dout[s], e.data);
          last[s] = e.data;
        end
      end
    end else if (er[s]) begin
      chk("err_alone", {31'd0, er[s]}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic chk_reset(input int s);
    chk("rst_busy", {31'd0, busy[s]}, 32'd0);
    chk("rst_rdy", {31'd0, drdy[s]}, 32'd0);
    chk("rst_wdone", {31'd0, wdn[s]}, 32'd0);
    chk("rst_err", {31'd0, er[s]}, 32'd0);
    chk("rst_dout", dout[s], 32'd0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rd[s]   = 1'b0;
      wr[s]   = 1'b0;
      ad[s]   = '0;
      din[s]  = '0;
      last[s] = '0;
      for (int w = 0; w < 2048; w++) mdl[s][w] = '0;
    end
    #3;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // write then read, next request accepted right after done
    issue(0, 0, 1, 32'h0000_0010, 32'h4433_2211);
    wait_done(0);
    issue(0, 1, 0, 32'h0000_0010, 32'h0);
    wait_done(0);

    // rd+wr together: served as write; rd pulse mid-busy ignored
    issue(0, 1, 1, 32'h0000_0020, 32'h0D0C_0B0A);
    rd[0] = 1'b1;
    ad[0] = 32'h0000_0010;
    @(negedge clk);
    rd[0] = 1'b0;
    wait_done(0);
    repeat (3) @(negedge clk);
    issue(0, 1, 0, 32'h0000_0020, 32'h0);
    wait_done(0);

    // out of range read and write
    issue(0, 1, 0, 32'h0000_2000, 32'h0);
    wait_done(0);
    issue(0, 0, 1, 32'h0000_2000, 32'hDEAD_BEEF);
    wait_done(0);
    issue(0, 1, 0, 32'h0000_0000, 32'h0);
    wait_done(0);
    issue(0, 1, 0, 32'h8000_0010, 32'h0);
    wait_done(0);

    // top word in range
    issue(0, 0, 1, 32'h0000_1FFC, 32'hCAFE_F00D);
    wait_done(0);
    issue(0, 1, 0, 32'h0000_1FFE, 32'h0);
    wait_done(0);

    // reset two cycles into a write aborts it
    issue(0, 0, 1, 32'h0000_0040, 32'hAABB_CCDD);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_reset(0);
    q.delete();
    last[0] = '0;
    last[1] = '0;
    @(negedge clk);
    rst = 1'b1;
    issue(0, 1, 0, 32'h0000_0040, 32'h0);
    wait_done(0);
    issue(0, 1, 0, 32'h0000_0010, 32'h0);
    wait_done(0);

    // LATENCY=1, back-to-back reads, addr[1:0] ignored
    issue(1, 0, 1, 32'h0000_0010, 32'h8765_4321);
    wait_done(1);
    issue(1, 1, 0, 32'h0000_0010, 32'h0);
    wait_done(1);
    issue(1, 1, 0, 32'h0000_0013, 32'h0);
    wait_done(1);
    issue(1, 0, 1, 32'h0000_0017, 32'h0102_0304);
    wait_done(1);
    issue(1, 1, 0, 32'h0000_0014, 32'h0);
    wait_done(1);

    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
